// File: rtl/router_pkg.sv
// Shared routing helpers for the buffered torus node router: derived widths,
// port numbering and the dimension-order route function.
package router_pkg;

    localparam int MAX_DIMS = 8;
    localparam int ADDR_MAX = 2 * MAX_DIMS;

    typedef logic [ADDR_MAX-1:0] addr_t;

    function automatic int n_stream_of(input int n_dims);
        return 2 * n_dims + 1;
    endfunction

    function automatic int net_width_of(input int n_dims);
        return 2 * n_dims;
    endfunction

    function automatic int PLUS(input int d);
        return 2 * d;
    endfunction

    function automatic int MINUS(input int d);
        return 2 * d + 1;
    endfunction

    function automatic int LOCAL_PORT(input int n_dims);
        return 2 * n_dims;
    endfunction

    // First differing digit decides the port; a delta of 2 on a 4-ring takes the + side.
    function automatic int route_port(input addr_t dest, input addr_t local_id, input int n_dims);
        int         port;
        logic       found;
        logic [1:0] delta;
        port  = LOCAL_PORT(n_dims);
        found = 1'b0;
        delta = 2'd0;
        for (int d = 0; d < MAX_DIMS; d++) begin
            if (!found && d < n_dims && dest[2*d +: 2] != local_id[2*d +: 2]) begin
                delta = dest[2*d +: 2] - local_id[2*d +: 2];
                port  = (delta == 2'd3) ? MINUS(d) : PLUS(d);
                found = 1'b1;
            end
        end
        return port;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after pointer, wrapping.
module rr_arbiter #(
    parameter int N = 5,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(pointer) + k) % N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buffered_node_router.sv
// Input-buffered dimension-order torus router: one FIFO per input, one
// round-robin arbitrated output register per output.
module buffered_node_router
    import router_pkg::*;
#(
    parameter int N_DIMS     = 2,
    parameter int DATA_WIDTH = 128,
    parameter int FIFO_DEPTH = 4,
    parameter logic [2*N_DIMS-1:0] LOCAL_ID = '0,
    localparam int NET_WIDTH    = net_width_of(N_DIMS),
    localparam int N_STREAM     = n_stream_of(N_DIMS),
    localparam int STREAM_WIDTH = DATA_WIDTH + NET_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_STREAM-1:0]                   in_valid,
    output logic [N_STREAM-1:0]                   in_ready,
    input  logic [N_STREAM-1:0][STREAM_WIDTH-1:0] in_data,
    output logic [N_STREAM-1:0]                   out_valid,
    input  logic [N_STREAM-1:0]                   out_ready,
    output logic [N_STREAM-1:0][STREAM_WIDTH-1:0] out_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SEL_W = $clog2(N_STREAM);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    logic [STREAM_WIDTH-1:0] mem     [N_STREAM][FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr  [N_STREAM];
    logic [PTR_W-1:0]        rd_ptr  [N_STREAM];
    logic [CNT_W-1:0]        count   [N_STREAM];
    logic [SEL_W-1:0]        rr_ptr  [N_STREAM];

    logic [STREAM_WIDTH-1:0] head_data [N_STREAM];
    int                      head_port [N_STREAM];
    addr_t                   dest_addr;
    logic [N_STREAM-1:0]     can_load;
    logic [N_STREAM-1:0]     req   [N_STREAM];
    logic [N_STREAM-1:0]     grant [N_STREAM];
    logic [N_STREAM-1:0]     load;
    logic [STREAM_WIDTH-1:0] sel_data [N_STREAM];
    logic [SEL_W-1:0]        sel_idx  [N_STREAM];
    logic [N_STREAM-1:0]     push;
    logic [N_STREAM-1:0]     pop;

    localparam addr_t LOCAL_ADDR = addr_t'(LOCAL_ID);

    always_comb begin
        for (int i = 0; i < N_STREAM; i++) begin
            in_ready[i] = (count[i] != FULL_COUNT);
            push[i]     = in_valid[i] && in_ready[i];
        end
    end

    always_comb begin
        dest_addr = '0;
        for (int i = 0; i < N_STREAM; i++) begin
            head_data[i] = mem[i][rd_ptr[i]];
            dest_addr    = '0;
            dest_addr[NET_WIDTH-1:0] = head_data[i][STREAM_WIDTH-1 -: NET_WIDTH];
            head_port[i] = route_port(dest_addr, LOCAL_ADDR, N_DIMS);
        end
    end

    // Each head names exactly one output, so no head can be claimed twice.
    always_comb begin
        for (int o = 0; o < N_STREAM; o++) begin
            can_load[o] = !out_valid[o] || out_ready[o];
            req[o]      = '0;
            for (int i = 0; i < N_STREAM; i++) begin
                req[o][i] = (count[i] != '0) && (head_port[i] == o) && can_load[o];
            end
        end
    end

    for (genvar o = 0; o < N_STREAM; o++) begin : g_arb
        rr_arbiter #(.N(N_STREAM)) u_arb (
            .req     (req[o]),
            .pointer (rr_ptr[o]),
            .grant   (grant[o])
        );
    end

    always_comb begin
        pop = '0;
        for (int o = 0; o < N_STREAM; o++) begin
            load[o]     = |grant[o];
            sel_data[o] = '0;
            sel_idx[o]  = '0;
            for (int i = 0; i < N_STREAM; i++) begin
                if (grant[o][i]) begin
                    sel_data[o] = head_data[i];
                    sel_idx[o]  = SEL_W'(i);
                    pop[i]      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_STREAM; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < N_STREAM; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= in_data[i];
                    wr_ptr[i]         <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CNT_W'(1);
                    2'b01:   count[i] <= count[i] - CNT_W'(1);
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // out_data only changes on a load, so it holds while the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            for (int o = 0; o < N_STREAM; o++) begin
                out_data[o] <= '0;
                rr_ptr[o]   <= '0;
            end
        end else begin
            for (int o = 0; o < N_STREAM; o++) begin
                if (load[o]) begin
                    out_valid[o] <= 1'b1;
                    out_data[o]  <= sel_data[o];
                    rr_ptr[o]    <= (sel_idx[o] == SEL_W'(N_STREAM - 1)) ? '0
                                                                         : sel_idx[o] + SEL_W'(1);
                end else if (out_ready[o]) begin
                    out_valid[o] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_buffered_node_router.sv
// Directed bench for buffered_node_router with N_DIMS=2, LOCAL_ID=4'b0110.
module tb_buffered_node_router;

    localparam int NS = 5;
    localparam int SW = 132;

    logic                    clk;
    logic                    rst;
    logic [NS-1:0]           in_valid;
    logic [NS-1:0]           in_ready;
    logic [NS-1:0][SW-1:0]   in_data;
    logic [NS-1:0]           out_valid;
    logic [NS-1:0]           out_ready;
    logic [NS-1:0][SW-1:0]   out_data;

    int n_checks = 0;
    int n_errors = 0;

    buffered_node_router #(
        .N_DIMS     (2),
        .DATA_WIDTH (128),
        .FIFO_DEPTH (4),
        .LOCAL_ID   (4'b0110)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] mk(input logic [3:0] dest, input int p);
        return {dest, 128'(p)};
    endfunction

    logic [3:0] dests    [6] = '{4'b0110, 4'b0111, 4'b0101, 4'b1010, 4'b0010, 4'b0100};
    int         exp_port [6] = '{4, 0, 1, 2, 3, 0};

    initial begin
        int acc;
        logic will_accept;
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '1;
        tick();
        check("rst_out_valid", 192'(out_valid), 192'(0));
        check("rst_out_data", 192'(out_data[4]), 192'(0));
        rst = 1'b0;
        check("rst_in_ready", 192'(in_ready), 192'(5'h1f));

        // Route table from the local input
        for (int k = 0; k < 6; k++) begin
            in_valid    = 5'b10000;
            in_data[4]  = mk(dests[k], 'h100 + k);
            tick();
            in_valid = '0;
            check("route_latency", 192'(out_valid), 192'(0));
            tick();
            check("route_valid", 192'(out_valid), 192'(1 << exp_port[k]));
            check("route_data", 192'(out_data[exp_port[k]]), 192'(mk(dests[k], 'h100 + k)));
            tick();
        end

        // Three inputs contending for the local output
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc < 3) begin
                in_valid = 5'b00111;
                for (int i = 0; i < 3; i++) in_data[i] = mk(4'b0110, i * 16 + cyc);
            end else begin
                in_valid = '0;
            end
            tick();
            if (cyc >= 1 && cyc <= 9) begin
                check("rr_order", 192'({out_valid[4], out_data[4]}),
                      192'({1'b1, mk(4'b0110, ((cyc - 1) % 3) * 16 + (cyc - 1) / 3)}));
            end else if (cyc == 10) begin
                check("rr_idle", 192'(out_valid[4]), 192'(0));
            end
        end

        // Backpressure: FIFO plus output register absorb FIFO_DEPTH+1 words
        out_ready = 5'b01111;
        acc       = 0;
        in_valid  = 5'b00001;
        for (int cyc = 0; cyc < 8; cyc++) begin
            in_data[0]  = mk(4'b0110, 'h300 + acc);
            will_accept = in_ready[0];
            tick();
            if (will_accept) acc++;
        end
        in_data[0] = mk(4'b0110, 'h300 + acc);
        check("bp_accepted", 192'(acc), 192'(5));
        check("bp_full", 192'(in_ready[0]), 192'(0));
        check("bp_hold", 192'({out_valid[4], out_data[4]}), 192'({1'b1, mk(4'b0110, 'h300)}));

        // Release while a push is offered to the full FIFO: push refused, pop proceeds
        out_ready = '1;
        tick();
        check("full_pop_ready", 192'(in_ready[0]), 192'(1));
        check("drain", 192'({out_valid[4], out_data[4]}), 192'({1'b1, mk(4'b0110, 'h301)}));
        for (int k = 2; k <= 5; k++) begin
            tick();
            in_valid = '0;
            check("drain", 192'({out_valid[4], out_data[4]}), 192'({1'b1, mk(4'b0110, 'h300 + k)}));
        end
        tick();
        check("drain_empty", 192'(out_valid[4]), 192'(0));

        // Pointer wrap through input 3
        for (int cyc = 0; cyc <= 13; cyc++) begin
            if (cyc < 12) begin
                in_valid   = 5'b01000;
                in_data[3] = mk(4'b0110, 'h500 + cyc);
            end else begin
                in_valid = '0;
            end
            tick();
            if (cyc >= 1 && cyc <= 12) begin
                check("wrap", 192'({out_valid[4], out_data[4]}),
                      192'({1'b1, mk(4'b0110, 'h500 + cyc - 1)}));
            end else if (cyc == 13) begin
                check("wrap_idle", 192'(out_valid[4]), 192'(0));
            end
        end

        // Reset with buffered words and a loaded output register
        out_ready = 5'b01111;
        in_valid  = 5'b00001;
        for (int c = 0; c < 3; c++) begin
            in_data[0] = mk(4'b0110, 'h600 + c);
            tick();
        end
        in_valid = '0;
        tick();
        check("pre_rst_valid", 192'(out_valid[4]), 192'(1));
        rst        = 1'b1;
        in_valid   = 5'b00010;
        in_data[1] = mk(4'b0110, 'h6ff);
        tick();
        rst      = 1'b0;
        in_valid = '0;
        check("mid_rst_valid", 192'(out_valid), 192'(0));
        check("mid_rst_data", 192'(out_data[4]), 192'(0));
        check("mid_rst_ready", 192'(in_ready), 192'(5'h1f));
        out_ready = '1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("no_stale", 192'(out_valid), 192'(0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
